// File: rtl/ddr3_phy_pkg.sv
// ddr3_phy_pkg: shared DQS strobe patterns, output-enable shapes and cycle classes for the DDR3 PHY lane logic.
package ddr3_phy_pkg;
  localparam logic [7:0] DQS_TOGGLE = 8'b01010101;
  localparam logic [3:0] OE_FULL = 4'hF;
  localparam logic [3:0] OE_PRE = 4'b1000;
  localparam logic [3:0] OE_POST = 4'b0001;
  localparam logic [3:0] OE_GAP = 4'b1001;
  typedef enum logic [2:0] {IDLE, PRE, DATA, POST, GAP} cyc_cls_e;
  function automatic cyc_cls_e classify(input logic cur, input logic prv, input logic nxt);
    return cur ? DATA : (nxt && !prv) ? PRE : (prv && !nxt) ? POST : (prv && nxt) ? GAP : IDLE;
  endfunction
  function automatic logic [3:0] oe_of(input cyc_cls_e c);
    return c == DATA ? OE_FULL : c == PRE ? OE_PRE : c == POST ? OE_POST : c == GAP ? OE_GAP : 4'h0;
  endfunction
endpackage

// File: rtl/ddr3_dqs_slot_sched.sv
// ddr3_dqs_slot_sched: data-slot shift register with write-request insertion and overlap detection.
module ddr3_dqs_slot_sched #(
  parameter int WR_LAT = 4,
  parameter int MAX_BURSTS = 8,
  parameter int DEPTH = WR_LAT + MAX_BURSTS + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic [3:0]       num,
  output logic [DEPTH-1:0] s_q,
  output logic [DEPTH-1:0] s_d,
  output logic             coll
);
  logic [3:0] n;
  logic [DEPTH-1:0] mask;
  logic [DEPTH-1:0] shifted;
  // Bit WR_LAT-1 of the post-insert register reaches S[0] in the cycle before data cycle t+WR_LAT+1.
  always_comb begin
    n = (num > 4'(MAX_BURSTS)) ? 4'(MAX_BURSTS) : num;
    mask = '0;
    for (int i = 0; i < MAX_BURSTS; i++) if (wr_req && i < int'(n)) mask[WR_LAT-1+i] = 1'b1;
    shifted = s_q >> 1;
    s_d = shifted | mask;
    coll = |(shifted & mask);
  end
  always_ff @(posedge clk) s_q <= rst ? '0 : s_d;
endmodule

// File: rtl/ddr3_dqs_tx_sched.sv
// ddr3_dqs_tx_sched: DQS write-strobe generator driving one byte lane's IOD TX data, output enable and ODT.
module ddr3_dqs_tx_sched
  import ddr3_phy_pkg::*;
#(
  parameter int WR_LAT = 4,
  parameter int MAX_BURSTS = 8
) (
  input  logic       FAB_CLK,
  input  logic       TX_SYNC_RST,
  input  logic       WR_REQ,
  input  logic [3:0] WR_NUM_BURSTS,
  input  logic       CLEAR_ERR,
  output logic [7:0] TX_DATA_0,
  output logic [3:0] OE_DATA_0,
  output logic       ODT_EN_0,
  output logic       WR_BUSY,
  output logic       COLLISION_ERR
);
  localparam int SCHED_DEPTH = WR_LAT + MAX_BURSTS + 2;
  logic [SCHED_DEPTH-1:0] s_q, s_d;
  logic coll;
  logic prv_q, prv_d, odt_q, odt_d, busy_q, busy_d, err_q, err_d;
  logic [7:0] tx_q, tx_d;
  logic [3:0] oe_q, oe_d, oe_nn;
  cyc_cls_e cls;
  ddr3_dqs_slot_sched #(.WR_LAT(WR_LAT), .MAX_BURSTS(MAX_BURSTS), .DEPTH(SCHED_DEPTH)) u_slot (
    .clk(FAB_CLK), .rst(TX_SYNC_RST), .wr_req(WR_REQ), .num(WR_NUM_BURSTS),
    .s_q(s_q), .s_d(s_d), .coll(coll)
  );
  // ODT looks one output cycle ahead, so the following cycle is classified from the post-insert schedule.
  always_comb begin
    cls = classify(s_q[0], prv_q, s_q[1]);
    tx_d = cls == DATA ? DQS_TOGGLE : 8'h00;
    oe_d = oe_of(cls);
    oe_nn = oe_of(classify(s_d[0], s_q[0], s_d[1]));
    prv_d = s_q[0];
    odt_d = ~(|{oe_q, oe_d, oe_nn});
    busy_d = (|s_d) || prv_d || (|oe_d);
    err_d = coll || (err_q && !CLEAR_ERR);
  end
  always_ff @(posedge FAB_CLK) begin
    prv_q <= TX_SYNC_RST ? 1'b0 : prv_d;
    tx_q <= TX_SYNC_RST ? 8'h00 : tx_d;
    oe_q <= TX_SYNC_RST ? 4'h0 : oe_d;
    odt_q <= TX_SYNC_RST ? 1'b1 : odt_d;
    busy_q <= TX_SYNC_RST ? 1'b0 : busy_d;
    err_q <= TX_SYNC_RST ? 1'b0 : err_d;
  end
  assign TX_DATA_0 = tx_q;
  assign OE_DATA_0 = oe_q;
  assign ODT_EN_0 = odt_q;
  assign WR_BUSY = busy_q;
  assign COLLISION_ERR = err_q;
endmodule
